// File: rtl/cipo_phase_select_reg.sv
// cipo_phase_select_reg: recovers a rising/falling-edge word pair from an oversampled CIPO line.
// clk          : single clock, all state updates on its rising edge
// rst          : asynchronous active-high reset, clears CIPO
// phase_select : cable-delay compensation, 0..15 oversampled-clock steps
// CIPO4x       : oversampled CIPO line, bit 0 is the earliest sample
// CIPO         : [15:0] rising-edge word, [31:16] falling-edge word, both MSB first
module cipo_phase_select_reg (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  phase_select,
   input  logic [73:0] CIPO4x,
   output logic [31:0] CIPO
);
   // Zero-padding to 128 entries makes every 7-bit index legal and turns
   // indices past the last sample into 0 instead of wrapping.
   logic [127:0] padded;
   logic [6:0]   base;
   logic [31:0]  sel;
   assign padded = {54'd0, CIPO4x};
   assign base   = {3'd0, phase_select};
   for (genvar k = 0; k < 16; k++) begin : g_bit
      assign sel[15-k] = padded[base + 7'(4*k)];
      assign sel[31-k] = padded[base + 7'(4*k + 2)];
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) CIPO <= '0;
      else     CIPO <= sel;
endmodule

// File: tb/tb_cipo_phase_select_reg.sv
// tb_cipo_phase_select_reg: scoreboard bench for cipo_phase_select_reg.
module tb_cipo_phase_select_reg;
   logic        clk;
   logic        rst;
   logic [3:0]  phase_select;
   logic [73:0] CIPO4x;
   logic [31:0] CIPO;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [31:0] exp_q[$];
   string       name_q[$];

   logic [73:0] ones;
   logic [73:0] one;
   logic [73:0] pat;

   cipo_phase_select_reg dut (
      .clk(clk),
      .rst(rst),
      .phase_select(phase_select),
      .CIPO4x(CIPO4x),
      .CIPO(CIPO)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   // Reference mapping: index = phase + 4k (+2 for the falling-edge word),
   // anything past sample 73 reads as 0.
   function automatic logic [31:0] model(input logic [3:0] p, input logic [73:0] x);
      logic [31:0] r;
      int ia, ib;
      r = '0;
      for (int k = 0; k < 16; k++) begin
         ia = int'(p) + 4*k;
         ib = ia + 2;
         r[15-k] = (ia <= 73) ? x[ia] : 1'b0;
         r[31-k] = (ib <= 73) ? x[ib] : 1'b0;
      end
      return r;
   endfunction

   task automatic check_now(input string nm, input logic [31:0] exp);
      n_cmp++;
      if (CIPO !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, CIPO, exp);
      end
   endtask

   // Drive a new input set between edges and queue what the register must
   // hold after the following rising edge.
   task automatic apply(input logic [3:0] p, input logic [73:0] x, input logic [31:0] exp, input string nm);
      @(negedge clk);
      phase_select = p;
      CIPO4x       = x;
      exp_q.push_back(exp);
      name_q.push_back(nm);
   endtask

   // Monitor: the register updates every edge, so each edge with a pending
   // expectation is a response to compare.
   initial begin
      logic [31:0] e;
      string       nm;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            check_now(nm, e);
         end
      end
   end

   initial begin
      logic [95:0] r96;
      logic [73:0] rx;
      logic [3:0]  rp;
      int          guard;
      ones = '1;
      one  = 74'd1;
      pat  = '0;
      for (int k = 0; k <= 18; k++) pat[4*k] = 1'b1;
      rst          = 0;
      phase_select = 0;
      CIPO4x       = ones;
      #2 rst = 1;
      #1 check_now("rst_async", 32'h00000000);
      @(negedge clk);
      check_now("rst_hold", 32'h00000000);
      @(negedge clk);
      rst = 0;
      exp_q.push_back(32'hFFFFFFFF);
      name_q.push_back("release_ones_p0");
      apply(4'd0, one,        32'h00008000, "bit0_p0");
      apply(4'd0, one << 2,   32'h80000000, "bit2_p0");
      apply(4'd0, one << 60,  32'h00000001, "bit60_p0");
      apply(4'd0, pat,        32'h0000FFFF, "pat_p0");
      apply(4'd2, pat,        32'hFFFF0000, "pat_p2");
      apply(4'd1, pat,        32'h00000000, "pat_p1");
      apply(4'd13, ones,      32'hFFFEFFFF, "ones_p13");
      apply(4'd14, ones,      32'hFFFEFFFE, "ones_p14");
      apply(4'd15, ones,      32'hFFFEFFFE, "ones_p15");
      apply(4'd11, ones,      32'hFFFFFFFF, "ones_p11");
      apply(4'd0, pat,        32'h0000FFFF, "lat_pre");
      @(negedge clk);
      phase_select = 4'd2;
      check_now("lat_hold", 32'h0000FFFF);
      exp_q.push_back(32'hFFFF0000);
      name_q.push_back("lat_post");
      for (int i = 0; i < 1000; i++) begin
         r96 = {$urandom, $urandom, $urandom};
         rx  = r96[73:0];
         rp  = 4'($urandom_range(15, 0));
         if (i == 500) begin
            @(negedge clk);
            phase_select = rp;
            CIPO4x       = rx;
            #1 rst = 1;
            #1 check_now("rst_mid", 32'h00000000);
            #1 rst = 0;
            exp_q.push_back(model(rp, rx));
            name_q.push_back("rand_after_rst");
         end else begin
            apply(rp, rx, model(rp, rx), "rand");
         end
      end
      guard = 0;
      while (exp_q.size() > 0 && guard < 10) begin
         @(negedge clk);
         guard++;
      end
      if (exp_q.size() > 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
